wb_arbiter: RTL

Writeback arbiter sitting between the functional units and the physical register file's single writeback port. Each FU pushes completed results (physical destination, data, epoch) into a small per-FU queue. A round-robin arbiter drains the queues into one registered writeback channel (wb_valid/wb_ready/wb_pd/wb_data/wb_epoch) that drives the PRF write port and the wakeup broadcast. Mispredict recovery purges entries tagged with a stale epoch, so squashed results never occupy writeback bandwidth.

---
 rtl/wb_arbiter_pkg.sv | 32 +++
 rtl/wb_fu_queue.sv | 107 ++++++++++
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared definitions for the writeback path. FU result buses, the per-FU
//   writeback queues and the PRF write port all carry a wb_entry_t.
//
//   FU_NUM    : default number of functional-unit result sources
//   PHYS_REGS : physical register count (PHYS_W = tag width)
//   DW        : result data width
//   EPOCH_W   : width of the branch epoch tag
//   QDEPTH    : default entries per FU queue (power of two, >= 2)
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int FU_NUM    = 4;
    localparam int PHYS_REGS = 64;
    localparam int DW        = 32;
    localparam int PHYS_W    = $clog2(PHYS_REGS);
    localparam int EPOCH_W   = 2;
    localparam int QDEPTH    = 2;

    typedef struct packed {
        logic [PHYS_W-1:0]  pd;
        logic [DW-1:0]      data;
        logic [EPOCH_W-1:0] epoch;
    } wb_entry_t;

    // Round-robin successor of idx among n sources.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_fu_queue.sv
// ---------------------------------------------------------------------------
// wb_fu_queue
//   Per-FU circular FIFO of completed results awaiting writeback.
//   On a flush edge every entry whose epoch differs from flush_epoch is
//   dropped and the survivors are compacted to slot 0 onward in their
//   original order; a same-cycle push is appended only if its epoch matches.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         enqueue push_entry (caller guarantees ready)
//   push_entry   entry to enqueue
//   pop          dequeue the head (caller guarantees head_valid, never on flush)
//   flush        purge stale-epoch entries this edge
//   flush_epoch  surviving epoch
//   ready        queue has a free slot (registered count only)
//   head_valid   queue is non-empty
//   head_entry   oldest entry
// ---------------------------------------------------------------------------
module wb_fu_queue
    import wb_arbiter_pkg::*;
#(
    parameter int QDEPTH = wb_arbiter_pkg::QDEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  wb_entry_t          push_entry,
    input  logic               pop,
    input  logic               flush,
    input  logic [EPOCH_W-1:0] flush_epoch,
    output logic               ready,
    output logic               head_valid,
    output wb_entry_t          head_entry
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    // Compacted image of the queue used on a flush edge.
    wb_entry_t        purge_mem [QDEPTH];
    logic [CNT_W-1:0] purge_cnt;

    assign ready      = (cnt < CNT_W'(QDEPTH));
    assign head_valid = (cnt != '0);
    assign head_entry = mem[head];

    // Walk the live entries oldest-first and pack the survivors densely.
    // purge_cnt never exceeds QDEPTH-1 before a write, so the low PTR_W bits
    // always address a real slot.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        purge_cnt = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            purge_mem[i] = '0;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < cnt) && (mem[idx].epoch == flush_epoch)) begin
                purge_mem[purge_cnt[PTR_W-1:0]] = mem[idx];
                purge_cnt = purge_cnt + CNT_W'(1);
            end
        end
        // push implies cnt < QDEPTH, so there is always room for it here.
        if (push && (push_entry.epoch == flush_epoch)) begin
            purge_mem[purge_cnt[PTR_W-1:0]] = push_entry;
            purge_cnt = purge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= purge_mem[i];
            end
            head <= '0;
            tail <= purge_cnt[PTR_W-1:0];
            cnt  <= purge_cnt;
        end else begin
            if (push) begin
                mem[tail] <= push_entry;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!push && pop) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Collects completed FU results in per-FU queues and drains them, one per
//   cycle, through a round-robin arbiter into a registered writeback channel
//   feeding the PRF write port and the wakeup broadcast. A flush purges
//   results from squashed epochs before they can use writeback bandwidth.
//
//   Handshakes: a transfer happens on a clock edge where valid and ready are
//   both high. fu_ready depends only on registered queue occupancy. Once
//   wb_valid is high, wb_pd/wb_data/wb_epoch/wb_src hold until a transfer;
//   the only exception is a flush, which may retract a stale-epoch entry.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fu_valid/fu_ready       per-FU result handshake
//   fu_pd/fu_data/fu_epoch  per-FU result payload
//   flush_valid/flush_epoch mispredict recovery, surviving epoch
//   wb_valid/wb_ready       writeback handshake
//   wb_pd/wb_data/wb_epoch  writeback payload
//   wb_src                  FU index that produced the current writeback
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int FU_NUM = wb_arbiter_pkg::FU_NUM,
    parameter  int QDEPTH = wb_arbiter_pkg::QDEPTH,
    localparam int SRC_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FU_NUM-1:0]  fu_valid,
    output logic [FU_NUM-1:0]  fu_ready,
    input  logic [PHYS_W-1:0]  fu_pd    [FU_NUM],
    input  logic [DW-1:0]      fu_data  [FU_NUM],
    input  logic [EPOCH_W-1:0] fu_epoch [FU_NUM],
    input  logic               flush_valid,
    input  logic [EPOCH_W-1:0] flush_epoch,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [PHYS_W-1:0]  wb_pd,
    output logic [DW-1:0]      wb_data,
    output logic [EPOCH_W-1:0] wb_epoch,
    output logic [SRC_W-1:0]   wb_src
);

    wb_entry_t         head_entry [FU_NUM];
    logic [FU_NUM-1:0] head_valid;
    logic [FU_NUM-1:0] push;
    logic [FU_NUM-1:0] pop;

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic              out_free;
    logic              load;
    wb_entry_t         sel_entry;

    // -----------------------------------------------------------------------
    // Per-FU queues
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < FU_NUM; g++) begin : g_q
        wb_entry_t in_entry;

        assign in_entry = '{pd: fu_pd[g], data: fu_data[g], epoch: fu_epoch[g]};
        assign push[g]  = fu_valid[g] && fu_ready[g];

        wb_fu_queue #(
            .QDEPTH (QDEPTH)
        ) u_queue (
            .clk         (clk),
            .rst_n       (rst_n),
            .push        (push[g]),
            .push_entry  (in_entry),
            .pop         (pop[g]),
            .flush       (flush_valid),
            .flush_epoch (flush_epoch),
            .ready       (fu_ready[g]),
            .head_valid  (head_valid[g]),
            .head_entry  (head_entry[g])
        );
    end

    // -----------------------------------------------------------------------
    // Round-robin grant: first non-empty head at or after rr_ptr.
    // -----------------------------------------------------------------------
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            idx = (int'(rr_ptr) + i) % FU_NUM;
            if (!gnt_valid && head_valid[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SRC_W'(idx);
            end
        end
    end

    assign out_free  = !wb_valid || wb_ready;
    // A flush edge never moves an entry into the output register, so a
    // survivor is not popped in the same edge its queue is being compacted.
    assign load      = out_free && gnt_valid && !flush_valid;
    assign sel_entry = head_entry[gnt_idx];

    always_comb begin
        pop = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            pop[i] = load && (gnt_idx == SRC_W'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Output register and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_pd    <= '0;
            wb_data  <= '0;
            wb_epoch <= '0;
            wb_src   <= '0;
            rr_ptr   <= '0;
        end else if (flush_valid) begin
            // A stale entry is retracted even if it is being accepted this
            // edge; the PRF discards it by epoch anyway. A matching entry that
            // transfers simply leaves the register empty.
            if (wb_valid && (wb_ready || (wb_epoch != flush_epoch))) begin
                wb_valid <= 1'b0;
            end
        end else if (out_free) begin
            if (gnt_valid) begin
                wb_valid <= 1'b1;
                wb_pd    <= sel_entry.pd;
                wb_data  <= sel_entry.data;
                wb_epoch <= sel_entry.epoch;
                wb_src   <= gnt_idx;
                rr_ptr   <= SRC_W'(rr_next(int'(gnt_idx), FU_NUM));
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule
